// File: rtl/counter_r0_arb.sv
// Round-robin sequencer that time-shares one counter_r0 among several requesters.
// The granted requester's interval length is latched (clamped below MAX_COUNT), the counter
// is loaded with 0 and run up to that length, then a one-cycle done pulse goes to the owner.
module counter_r0_arb #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_COUNT = 100,
  parameter int unsigned BIT_WIDTH = $clog2(MAX_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic                         ctr_load,
  output logic                         ctr_run,
  output logic [BIT_WIDTH-1:0]         ctr_dataIn,
  input  logic [BIT_WIDTH-1:0]         ctr_count
);

  localparam int unsigned OwnerW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BIT_WIDTH-1:0] MaxLen = BIT_WIDTH'(MAX_COUNT - 1);
  localparam logic [OwnerW-1:0] LastReq = OwnerW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [OwnerW-1:0]    owner_q, owner_d;
  logic [OwnerW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BIT_WIDTH-1:0] len_q, len_d;

  logic [OwnerW-1:0]    pick;
  logic                 pick_valid;
  logic [BIT_WIDTH-1:0] pick_len_raw;
  logic [BIT_WIDTH-1:0] pick_len;

  // Round-robin search: first asserted request after rr_ptr, wrapping around.
  always_comb begin
    int unsigned  idx;
    logic [OwnerW-1:0] cand;
    pick       = rr_ptr_q;
    pick_valid = 1'b0;
    idx        = 0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = OwnerW'(idx);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Length of the picked requester, clamped so the counter never has to wrap.
  always_comb begin
    pick_len_raw = req_len[BIT_WIDTH*pick +: BIT_WIDTH];
    pick_len     = (pick_len_raw > MaxLen) ? MaxLen : pick_len_raw;
  end

  // Next-state logic and all counter/grant outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    len_d    = len_q;
    gnt      = '0;
    done     = '0;
    ctr_load = 1'b0;
    ctr_run  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d  = pick;
          rr_ptr_d = pick;
          len_d    = pick_len;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        gnt[owner_q] = 1'b1;
        ctr_load     = 1'b1;
        state_d      = req[owner_q] ? StRun : StIdle;
      end
      StRun: begin
        gnt[owner_q] = 1'b1;
        if (!req[owner_q]) begin
          // Withdrawn: stop the counter now, leave without a done pulse.
          state_d = StIdle;
        end else if (ctr_count == len_q) begin
          state_d = StDone;
        end else begin
          ctr_run = 1'b1;
        end
      end
      StDone: begin
        gnt[owner_q]  = 1'b1;
        done[owner_q] = 1'b1;
        state_d       = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign ctr_dataIn = '0;

  // State registers; synchronous reset points rr_ptr at the last requester so 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= LastReq;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      len_q    <= len_d;
    end
  end

endmodule
